// File: rtl/png_chunk_crc_ctrl_pkg.sv
// rtl/png_chunk_crc_ctrl_pkg.sv - shared widths, state encoding and PNG chunk type codes
package png_chunk_crc_ctrl_pkg;

    localparam int DATA_WD = 32;
    localparam int LEN_WD  = 31;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_TYP  = 3'd2,
        ST_DAT  = 3'd3,
        ST_WAIT = 3'd4,
        ST_CRC  = 3'd5
    } state_e;

    // Chunk types as big-endian ASCII words
    localparam logic [DATA_WD-1:0] PNG_IHDR = 32'h4948_4452;
    localparam logic [DATA_WD-1:0] PNG_IDAT = 32'h4944_4154;
    localparam logic [DATA_WD-1:0] PNG_IEND = 32'h4945_4E44;

endpackage

// File: rtl/png_chunk_crc_ctrl.sv
// rtl/png_chunk_crc_ctrl.sv - sequences one PNG chunk into {LENGTH, TYPE, DATA..., CRC} and drives the crc32 core
module png_chunk_crc_ctrl #(
    parameter int DATA_WD = png_chunk_crc_ctrl_pkg::DATA_WD,
    parameter int LEN_WD  = png_chunk_crc_ctrl_pkg::LEN_WD
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               chk_start_i,
    input  logic [LEN_WD-1:0]  chk_len_i,
    input  logic [DATA_WD-1:0] chk_typ_i,
    output logic               chk_rdy_o,
    input  logic               val_i,
    input  logic [DATA_WD-1:0] dat_i,
    output logic               rdy_o,
    output logic               val_o,
    output logic [DATA_WD-1:0] dat_o,
    output logic               lst_o,
    input  logic               rdy_i,
    output logic               crc_start_o,
    output logic               crc_val_o,
    output logic [DATA_WD-1:0] crc_dat_o,
    output logic               crc_lst_o,
    input  logic               crc_done_i,
    input  logic               crc_val_i,
    input  logic [DATA_WD-1:0] crc_dat_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);
    import png_chunk_crc_ctrl_pkg::*;

    localparam int CNT_WD = LEN_WD - 2;
    localparam logic [CNT_WD-1:0] WCNT_ONE = CNT_WD'(1);

    state_e              state_q, state_d;
    logic [LEN_WD-1:0]   len_q, len_d;
    logic [DATA_WD-1:0]  typ_q, typ_d;
    logic [DATA_WD-1:0]  crc_q, crc_d;
    logic [CNT_WD-1:0]   wcnt_q, wcnt_d;
    logic                err_q, err_d;

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            typ_q   <= '0;
            crc_q   <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            typ_q   <= typ_d;
            crc_q   <= crc_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        typ_d       = typ_q;
        crc_d       = crc_q;
        wcnt_d      = wcnt_q;
        err_d       = err_q;
        chk_rdy_o   = 1'b0;
        rdy_o       = 1'b0;
        val_o       = 1'b0;
        dat_o       = '0;
        lst_o       = 1'b0;
        crc_start_o = 1'b0;
        crc_val_o   = 1'b0;
        crc_dat_o   = '0;
        crc_lst_o   = 1'b0;
        done_o      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                chk_rdy_o = 1'b1;
                // Suppressed during reset so the core is not cleared by a request that is about to be dropped
                if (chk_start_i && !rstn) begin
                    len_d  = chk_len_i;
                    typ_d  = chk_typ_i;
                    wcnt_d = chk_len_i[LEN_WD-1:2];
                    err_d  = |chk_len_i[1:0];
                    if (chk_len_i[1:0] == 2'b00) begin
                        crc_start_o = 1'b1;
                        state_d     = ST_LEN;
                    end
                end
            end
            ST_LEN: begin
                val_o = 1'b1;
                dat_o = {{(DATA_WD-LEN_WD){1'b0}}, len_q};
                if (rdy_i) state_d = ST_TYP;
            end
            ST_TYP: begin
                val_o = 1'b1;
                dat_o = typ_q;
                if (rdy_i) begin
                    crc_val_o = 1'b1;
                    crc_dat_o = typ_q;
                    crc_lst_o = (wcnt_q == '0);
                    state_d   = (wcnt_q == '0) ? ST_WAIT : ST_DAT;
                end
            end
            ST_DAT: begin
                // Pass-through so the core only sees words the consumer actually took
                val_o = val_i;
                dat_o = dat_i;
                rdy_o = rdy_i;
                if (val_i && rdy_i) begin
                    crc_val_o = 1'b1;
                    crc_dat_o = dat_i;
                    crc_lst_o = (wcnt_q == WCNT_ONE);
                    wcnt_d    = wcnt_q - WCNT_ONE;
                    if (wcnt_q == WCNT_ONE) state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (crc_done_i && crc_val_i) begin
                    crc_d   = crc_dat_i;
                    state_d = ST_CRC;
                end
            end
            ST_CRC: begin
                val_o = 1'b1;
                dat_o = crc_q;
                lst_o = 1'b1;
                if (rdy_i) begin
                    done_o  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o = (state_q != ST_IDLE);
    assign err_o  = err_q;

endmodule

// File: tb/tb_png_chunk_crc_ctrl.sv
// tb/tb_png_chunk_crc_ctrl.sv - self-checking bench for png_chunk_crc_ctrl with a behavioural crc32 core
module tb_png_chunk_crc_ctrl;
    import png_chunk_crc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        chk_start_i = 1'b0;
    logic [30:0] chk_len_i = '0;
    logic [31:0] chk_typ_i = '0;
    logic        chk_rdy_o;
    logic        val_i = 1'b0;
    logic [31:0] dat_i = '0;
    logic        rdy_o;
    logic        val_o;
    logic [31:0] dat_o;
    logic        lst_o;
    logic        rdy_i = 1'b0;
    logic        crc_start_o;
    logic        crc_val_o;
    logic [31:0] crc_dat_o;
    logic        crc_lst_o;
    logic        crc_done_i = 1'b0;
    logic        crc_val_i = 1'b0;
    logic [31:0] crc_dat_i = '0;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    always #5 clk = ~clk;

    png_chunk_crc_ctrl dut (
        .clk(clk), .rstn(rstn),
        .chk_start_i(chk_start_i), .chk_len_i(chk_len_i), .chk_typ_i(chk_typ_i), .chk_rdy_o(chk_rdy_o),
        .val_i(val_i), .dat_i(dat_i), .rdy_o(rdy_o),
        .val_o(val_o), .dat_o(dat_o), .lst_o(lst_o), .rdy_i(rdy_i),
        .crc_start_o(crc_start_o), .crc_val_o(crc_val_o), .crc_dat_o(crc_dat_o), .crc_lst_o(crc_lst_o),
        .crc_done_i(crc_done_i), .crc_val_i(crc_val_i), .crc_dat_i(crc_dat_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Reference CRC-32 (PNG/zlib, reflected poly) over a byte sequence
    function automatic logic [31:0] crc32_of(input byte unsigned b[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c ^= {24'h0, b[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    typedef struct {
        logic [30:0] len;
        logic [31:0] typ;
        bit          stall;
        bit          mid;
        bit          ramp;
        logic [31:0] fixed_crc;
    } vec_t;

    logic [31:0]  src[$];
    int           src_idx;
    bit           stall, mid, start_req;
    int           step_no = 0;
    logic [31:0]  out_q[$];
    int           lst_cnt, lst_pos, done_cnt, crc_val_cnt, crc_start_cnt;
    logic [31:0]  crc_lst_word;
    int           first_val_step, crc_off_step, done_drv_step, accept_step;
    byte unsigned core_b[$];
    int           core_cnt = 0;
    logic [31:0]  core_res;

    // One clock: drive just after the rising edge, observe at the falling edge
    task automatic step();
        @(posedge clk);
        #1;
        step_no++;
        chk_start_i = start_req | (mid && src_idx > 0 && src_idx < src.size() && $urandom_range(0, 1) == 1);
        val_i = (src_idx < src.size()) && (!stall || $urandom_range(0, 2) != 0);
        dat_i = (src_idx < src.size()) ? src[src_idx] : $urandom;
        rdy_i = !stall || $urandom_range(0, 2) != 0;
        crc_done_i = 1'b0;
        crc_val_i  = 1'b0;
        crc_dat_i  = $urandom;
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                crc_done_i    = 1'b1;
                crc_val_i     = 1'b1;
                crc_dat_i     = core_res;
                done_drv_step = step_no;
            end
        end
        @(negedge clk);
        if (rstn) begin
            core_cnt = 0;
            core_b.delete();
        end else begin
            if (val_o && first_val_step < 0) first_val_step = step_no;
            if (val_o && lst_o && crc_off_step < 0) crc_off_step = step_no;
            if (val_o && rdy_i) begin
                out_q.push_back(dat_o);
                if (lst_o) begin
                    lst_cnt++;
                    lst_pos = out_q.size() - 1;
                end
            end
            if (val_i && rdy_o) src_idx++;
            if (done_o) done_cnt++;
            if (crc_start_o) begin
                crc_start_cnt++;
                core_b.delete();
            end
            if (crc_val_o) begin
                crc_val_cnt++;
                for (int k = 3; k >= 0; k--) core_b.push_back(crc_dat_o[8*k +: 8]);
                if (crc_lst_o) begin
                    crc_lst_word = crc_dat_o;
                    core_res     = crc32_of(core_b);
                    core_cnt     = $urandom_range(1, 3);
                end
            end
        end
    endtask

    task automatic begin_chunk(input logic [30:0] len, input logic [31:0] typ, input bit st, input bit md, input bit ramp);
        int n;
        src.delete();
        out_q.delete();
        src_idx = 0; lst_cnt = 0; lst_pos = -1; done_cnt = 0; crc_val_cnt = 0; crc_start_cnt = 0;
        crc_lst_word = 'x; first_val_step = -1; crc_off_step = -1; done_drv_step = -1;
        stall = st; mid = md;
        n = (len[1:0] == 2'b00) ? int'(len >> 2) : 0;
        for (int i = 0; i < n; i++)
            src.push_back(ramp ? {8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 8'(4*i+4)} : $urandom);
        chk_len_i = len;
        chk_typ_i = typ;
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        accept_step = step_no;
    endtask

    task automatic run_chunk(input vec_t v);
        bit          exp_err;
        int          n, guard;
        byte unsigned eb[$];
        logic [31:0] exp_crc;
        exp_err = (v.len[1:0] != 2'b00);
        begin_chunk(v.len, v.typ, v.stall, v.mid, v.ramp);
        chk("accept_chk_rdy", 32'(chk_rdy_o), 32'd1);
        chk("accept_crc_start", 32'(crc_start_o), 32'(!exp_err));
        if (exp_err) begin
            for (int i = 0; i < 4; i++) step();
            chk("err_set", 32'(err_o), 32'd1);
            chk("err_busy", 32'(busy_o), 32'd0);
            chk("err_no_words", 32'(out_q.size()), 32'd0);
            chk("err_no_crc_start", 32'(crc_start_cnt), 32'd0);
            return;
        end
        n = src.size();
        guard = 0;
        while (done_cnt == 0 && guard < 2000) begin
            step();
            guard++;
        end
        chk("chunk_timeout", 32'(done_cnt != 0), 32'd1);
        for (int k = 3; k >= 0; k--) eb.push_back(v.typ[8*k +: 8]);
        foreach (src[i]) for (int k = 3; k >= 0; k--) eb.push_back(src[i][8*k +: 8]);
        exp_crc = crc32_of(eb);
        if (v.fixed_crc != 32'h0) chk("crc_known_value", exp_crc, v.fixed_crc);
        chk("word_count", 32'(out_q.size()), 32'(n + 3));
        if (out_q.size() == n + 3) begin
            chk("word_len", out_q[0], {1'b0, v.len});
            chk("word_typ", out_q[1], v.typ);
            for (int i = 0; i < n; i++) chk($sformatf("word_dat%0d", i), out_q[2+i], src[i]);
            chk("word_crc", out_q[n+2], exp_crc);
        end
        chk("lst_count", 32'(lst_cnt), 32'd1);
        chk("lst_pos", 32'(lst_pos), 32'(n + 2));
        chk("crc_val_count", 32'(crc_val_cnt), 32'(n + 1));
        chk("crc_lst_word", crc_lst_word, (n == 0) ? v.typ : src[n-1]);
        chk("crc_start_count", 32'(crc_start_cnt), 32'd1);
        chk("first_word_latency", 32'(first_val_step - accept_step), 32'd1);
        chk("crc_word_latency", 32'(crc_off_step - done_drv_step), 32'd1);
        chk("err_clear", 32'(err_o), 32'd0);
        mid = 1'b0;
        step();
        chk("done_once", 32'(done_cnt), 32'd1);
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_chk_rdy", 32'(chk_rdy_o), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_chk_rdy"}, 32'(chk_rdy_o), 32'd1);
        chk({tag, "_val_o"}, 32'(val_o), 32'd0);
        chk({tag, "_lst_o"}, 32'(lst_o), 32'd0);
        chk({tag, "_rdy_o"}, 32'(rdy_o), 32'd0);
        chk({tag, "_crc_out"}, 32'({crc_start_o, crc_val_o, crc_lst_o}), 32'd0);
        chk({tag, "_crc_dat"}, crc_dat_o, 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_err"}, 32'(err_o), 32'd0);
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{len: 31'd0,  typ: PNG_IEND, stall: 1'b0, mid: 1'b0, ramp: 1'b0, fixed_crc: 32'hAE42_6082};
        tbl[1] = '{len: 31'd8,  typ: PNG_IDAT, stall: 1'b0, mid: 1'b0, ramp: 1'b1, fixed_crc: 32'h0};
        tbl[2] = '{len: 31'd32, typ: PNG_IDAT, stall: 1'b1, mid: 1'b0, ramp: 1'b0, fixed_crc: 32'h0};
        tbl[3] = '{len: 31'd6,  typ: PNG_IDAT, stall: 1'b0, mid: 1'b0, ramp: 1'b0, fixed_crc: 32'h0};
        tbl[4] = '{len: 31'd4,  typ: PNG_IHDR, stall: 1'b0, mid: 1'b0, ramp: 1'b0, fixed_crc: 32'h0};
        tbl[5] = '{len: 31'd32, typ: PNG_IDAT, stall: 1'b1, mid: 1'b1, ramp: 1'b0, fixed_crc: 32'h0};

        src.delete();
        src_idx = 0; stall = 1'b0; mid = 1'b0; start_req = 1'b0;
        rstn = 1'b1;
        repeat (3) step();
        rstn = 1'b0;
        step();
        chk_reset_outputs("reset");

        for (int i = 0; i < 6; i++) run_chunk(tbl[i]);

        // Reset in the middle of the data phase abandons the chunk
        begin_chunk(31'd16, PNG_IDAT, 1'b0, 1'b0, 1'b0);
        for (int g = 0; g < 50 && src_idx < 2; g++) step();
        chk("mid_reset_in_dat", 32'(rdy_o), 32'd1);
        rstn = 1'b1;
        step();
        rstn = 1'b0;
        src.delete();
        src_idx = 0;
        done_cnt = 0;
        step();
        chk_reset_outputs("mid_reset");
        chk("mid_reset_no_done", 32'(done_cnt), 32'd0);
        run_chunk('{len: 31'd12, typ: PNG_IDAT, stall: 1'b0, mid: 1'b0, ramp: 1'b0, fixed_crc: 32'h0});

        for (int r = 0; r < 6; r++) begin
            vec_t v;
            v.len       = 31'($urandom_range(0, 12) * 4);
            v.typ       = ($urandom_range(0, 1) == 1) ? PNG_IDAT : PNG_IHDR;
            v.stall     = $urandom_range(0, 1) == 1;
            v.mid       = $urandom_range(0, 1) == 1;
            v.ramp      = 1'b0;
            v.fixed_crc = 32'h0;
            run_chunk(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/png_chunk_crc_ctrl.md
Name: png_chunk_crc_ctrl

Overview:
Sequencer that turns one PNG chunk (length, type, data words) into an output word stream {LENGTH, TYPE, DATA..., CRC}. It drives the 32-bit crc32 core over the TYPE and DATA words and appends the CRC result. It sits between the IDAT/IHDR/IEND chunk producers and the byte serializer of the PNG encoder.

Parameters:
DATA_WD, 32, word width of data and CRC paths; fixed, all other widths derive from it
LEN_WD, 31, chunk byte-length width; PNG maximum is 2^31-1

Ports:
clk  in  1  single clock
rstn  in  1  reset; synchronous, active-high despite the name
chk_start_i  in  1  chunk request; accepted only in IDLE
chk_len_i  in  LEN_WD  data byte length; sampled on accept; must be a multiple of 4
chk_typ_i  in  DATA_WD  chunk type, big-endian ASCII; sampled on accept
chk_rdy_o  out  1  high in IDLE only
val_i  in  1  upstream data word valid
dat_i  in  DATA_WD  upstream data word
rdy_o  out  1  upstream ready, equal to rdy_i in DAT, else 0
val_o  out  1  downstream word valid
dat_o  out  DATA_WD  downstream word
lst_o  out  1  marks the CRC word, the last word of the chunk
rdy_i  in  1  downstream ready
crc_start_o  out  1  one-cycle pulse clearing the crc32 core
crc_val_o  out  1  word valid to the core
crc_dat_o  out  DATA_WD  word to the core
crc_lst_o  out  1  last word to the core
crc_done_i  in  1  core finished
crc_val_i  in  1  core result valid
crc_dat_i  in  DATA_WD  core CRC result
busy_o  out  1  high outside IDLE
done_o  out  1  one-cycle pulse when the CRC word transfers
err_o  out  1  sticky; set when chk_len_i[1:0]!=0 on accept; cleared by the next accept or by reset

Behaviour:
- Reset: all outputs 0 except chk_rdy_o=1. State=IDLE, counters and latches cleared.
- Transfer: a downstream word transfers when val_o&rdy_i. An upstream word transfers when val_i&rdy_o.
- IDLE:
  - On chk_start_i: latch len and typ; load wcnt=len>>2; pulse crc_start_o in the same cycle.
  - If len[1:0]!=0: set err_o, do not pulse crc_start_o, stay in IDLE.
  - Otherwise go to LEN.
- LEN: val_o=1, dat_o={0,len} zero-extended. On transfer go to TYP.
- TYP: val_o=1, dat_o=typ. On transfer:
  - crc_val_o=1, crc_dat_o=typ, crc_lst_o=(wcnt==0).
  - Go to WAIT if wcnt==0, else DAT.
- DAT: combinational pass-through: val_o=val_i, dat_o=dat_i, rdy_o=rdy_i. On transfer:
  - crc_val_o=1, crc_dat_o=dat_i, crc_lst_o=(wcnt==1); wcnt decrements.
  - When wcnt==1 transfers, go to WAIT.
- WAIT: val_o=0. On crc_done_i&crc_val_i, latch crc_dat_i into crc_q and go to CRC. There is no timeout.
- CRC: val_o=1, dat_o=crc_q, lst_o=1. On transfer pulse done_o and go to IDLE.
- The crc_* outputs are 0 whenever no CRC-feeding transfer occurs. The core is never fed without backpressure: a word goes to the core only in the cycle it transfers downstream.
- chk_start_i while busy is ignored, not queued.
- A core result arriving outside WAIT is ignored.
- Reset mid-chunk: immediate return to IDLE. The partial chunk is abandoned and no done_o is produced. The next chunk re-pulses crc_start_o.
- Latency:
  - First word (LENGTH) is offered the cycle after accept.
  - CRC word is offered the cycle after crc_done_i.
  - Zero-stall chunk with N data words: N+3 output words plus the core latency.

Decomposition:
- Shared package holds:
  - state encoding: IDLE, LEN, TYP, DAT, WAIT, CRC
  - DATA_WD and LEN_WD
  - PNG type constants: IHDR 0x49484452, IDAT 0x49444154, IEND 0x49454E44
- No sub-module. The crc32 core is instantiated by the parent, not inside this block.

Test Plan:
- IEND, len=0, typ=0x49454E44, rdy_i=1 -> output 0x00000000, 0x49454E44, 0xAE426082 with lst_o=1; crc_lst_o with the type word; done_o pulse.
- len=8, data 0x01020304, 0x05060708 -> 5 output words; exactly 3 crc_val_o pulses; crc_lst_o on 0x05060708; CRC word equals the reference-model CRC of type+data.
- Random rdy_i/val_i stalls during an 8-word IDAT -> word order and CRC unchanged; crc_val_o count equals 9 (type plus 8 data words); no word lost or duplicated.
- len=6 -> err_o=1, no crc_start_o, busy_o=0, no output words; then len=4 -> err_o clears and the chunk completes normally.
- chk_start_i pulsed during DAT -> ignored; current chunk completes unchanged.
- rstn asserted in DAT -> next cycle all outputs at reset values; a new chunk then completes with the correct CRC.
